pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 137 +++++++++++++
 tb/tb_pll_reset_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Sequences a PLL out of reset: pulses the PLL reset pin, waits for lock,
//   requires the lock to hold for a qualification window and then releases
//   the downstream reset. Lock losses and lock timeouts restart the sequence.
//   A standby request in RUN parks the PLL until the request drops.
//
// Ports
//   refclk      in   free-running reference clock (sole clock)
//   reset       in   synchronous active-high block reset
//   extlock     in   PLL lock flag, asynchronous to refclk
//   stdby_req   in   standby request, synchronous to refclk
//   pll_reset   out  PLL reset pin
//   pll_stdby   out  PLL standby pin
//   sys_rst     out  active-high reset for logic on PLL clocks
//   locked      out  high only in RUN
//   relock_cnt  out  saturating count of lock losses seen in RUN
//   timeout_err out  sticky: a lock timeout has occurred
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | PLL reset asserted for RST_CYCLES cycles
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
// STABLE    | lock must stay high for STABLE_CYCLES consecutive cycles
// RUN       | lock qualified, downstream reset released
// STANDBY   | PLL held in standby until stdby_req drops
module pll_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 20000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  input  logic       stdby_req,
  output logic       pll_reset,
  output logic       pll_stdby,
  output logic       sys_rst,
  output logic       locked,
  output logic [7:0] relock_cnt,
  output logic       timeout_err
);

  localparam int MAX_RT  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  // Terminal counts: the counter reads 0 on the entry edge, so the exit
  // edge is the one that sees N-1, giving exactly N cycles in the state.
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    STANDBY
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          lock_m;
  logic          lock_s;
  logic          relock_evt;
  logic          timeout_evt;

  always_comb begin
    state_nxt   = state;
    relock_evt  = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the would-be timeout edge still counts as a lock.
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = PLL_RST;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                   state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_nxt = RUN;
      end
      RUN: begin
        // Standby has priority over a simultaneous lock loss.
        if (stdby_req) begin
          state_nxt = STANDBY;
        end else if (!lock_s) begin
          state_nxt  = PLL_RST;
          relock_evt = 1'b1;
        end
      end
      STANDBY: begin
        if (!stdby_req) state_nxt = PLL_RST;
      end
      default: state_nxt = PLL_RST;
    endcase
  end

  // Outputs decode state_nxt so they change on the same edge as state.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      pll_reset   <= 1'b1;
      pll_stdby   <= 1'b0;
      sys_rst     <= 1'b1;
      locked      <= 1'b0;
      relock_cnt  <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      lock_m <= extlock;
      lock_s <= lock_m;
      state  <= state_nxt;
      // RUN and STANDBY are untimed, so the counter just idles at zero there.
      if ((state_nxt != state) || (state == RUN) || (state == STANDBY))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      pll_reset <= (state_nxt == PLL_RST);
      pll_stdby <= (state_nxt == STANDBY);
      sys_rst   <= (state_nxt != RUN);
      locked    <= (state_nxt == RUN);
      if (timeout_evt) timeout_err <= 1'b1;
      if (relock_evt && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//   Self-checking bench for pll_reset_seq with RST_CYCLES=4, LOCK_TIMEOUT=32,
//   STABLE_CYCLES=8. Expected event times are derived arithmetically from
//   the sequencing rules (reset pulse length, two-flop lock latency,
//   timeout period, qualification window) for randomized stimulus.
//   Edge numbering: t=0 is the reference edge of each scenario; inputs for
//   edge t are driven before it, outputs are sampled 1 ns after it.
module tb_pll_reset_seq;
  localparam int RST_C = 4;
  localparam int TO_C  = 32;
  localparam int ST_C  = 8;
  localparam int LOCK_LAT = RST_C + 1 + ST_C;

  logic       refclk = 1'b0;
  logic       reset;
  logic       extlock;
  logic       stdby_req;
  logic       pll_reset;
  logic       pll_stdby;
  logic       sys_rst;
  logic       locked;
  logic [7:0] relock_cnt;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;
  int model_relock = 0;

  pll_reset_seq #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO_C),
    .STABLE_CYCLES(ST_C)
  ) dut (
    .refclk     (refclk),
    .reset      (reset),
    .extlock    (extlock),
    .stdby_req  (stdby_req),
    .pll_reset  (pll_reset),
    .pll_stdby  (pll_stdby),
    .sys_rst    (sys_rst),
    .locked     (locked),
    .relock_cnt (relock_cnt),
    .timeout_err(timeout_err)
  );

  always #5 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench 1 ns after the last edge that samples reset=1 (t=0).
  task automatic apply_reset(input int len);
    reset     = 1'b1;
    stdby_req = 1'b0;
    repeat (len) step();
    reset = 1'b0;
    model_relock = 0;
  endtask

  task automatic wait_lock(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (locked === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    extlock = 1'($urandom_range(0, 1));
    apply_reset($urandom_range(1, 5));
    total++; if (pll_reset !== 1'b1)   begin bad++; $display("FAIL reset_pll_reset got=%b exp=1", pll_reset); end
    total++; if (pll_stdby !== 1'b0)   begin bad++; $display("FAIL reset_pll_stdby got=%b exp=0", pll_stdby); end
    total++; if (sys_rst !== 1'b1)     begin bad++; $display("FAIL reset_sys_rst got=%b exp=1", sys_rst); end
    total++; if (locked !== 1'b0)      begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (relock_cnt !== 8'd0)  begin bad++; $display("FAIL reset_relock_cnt got=%0d exp=0", relock_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_lock_nominal();
    int t_fall;
    t_fall  = -1;
    extlock = 1'b1;
    apply_reset(3);
    for (int t = 1; t <= 30; t++) begin
      step();
      if (t_fall < 0 && pll_reset === 1'b0) t_fall = t;
      total++; if (locked !== 1'(t >= LOCK_LAT)) begin bad++; $display("FAIL nom_locked t=%0d got=%b exp=%b", t, locked, t >= LOCK_LAT); end
      total++; if (sys_rst !== 1'(t < LOCK_LAT)) begin bad++; $display("FAIL nom_sys_rst t=%0d got=%b exp=%b", t, sys_rst, t < LOCK_LAT); end
    end
    total++; if (t_fall != RST_C)       begin bad++; $display("FAIL nom_pulse_len got=%0d exp=%0d", t_fall, RST_C); end
    total++; if (relock_cnt !== 8'd0)   begin bad++; $display("FAIL nom_relock_cnt got=%0d exp=0", relock_cnt); end
    total++; if (timeout_err !== 1'b0)  begin bad++; $display("FAIL nom_timeout_err got=%b exp=0", timeout_err); end
    total++; if (pll_stdby !== 1'b0)    begin bad++; $display("FAIL nom_pll_stdby got=%b exp=0", pll_stdby); end
  endtask

  task automatic test_timeout();
    int tstop, phase, stab, run_exp;
    tstop = $urandom_range(40, 140);
    phase = tstop % (TO_C + RST_C);
    if (phase < RST_C) begin
      stab = tstop - phase + RST_C + 1;
      if (stab < tstop + 3) stab = tstop + 3;
    end else if (tstop - phase + TO_C + RST_C >= tstop + 3) begin
      stab = tstop + 3;
    end else begin
      stab = tstop - phase + TO_C + RST_C + RST_C + 1;
    end
    run_exp = stab + ST_C;
    extlock = 1'b0;
    apply_reset(2);
    for (int t = 1; t <= tstop + 50; t++) begin
      extlock = 1'(t > tstop);
      step();
      if (t <= tstop) begin
        total++; if (pll_reset !== 1'((t % (TO_C + RST_C)) < RST_C)) begin bad++; $display("FAIL to_pll_reset t=%0d got=%b", t, pll_reset); end
      end
      total++; if (timeout_err !== 1'(t >= TO_C + RST_C)) begin bad++; $display("FAIL to_timeout_err t=%0d got=%b", t, timeout_err); end
      total++; if (locked !== 1'(t >= run_exp)) begin bad++; $display("FAIL to_locked t=%0d got=%b exp_run=%0d", t, locked, run_exp); end
      total++; if (sys_rst !== 1'(t < run_exp)) begin bad++; $display("FAIL to_sys_rst t=%0d got=%b exp_run=%0d", t, sys_rst, run_exp); end
    end
    total++; if (relock_cnt !== 8'd0) begin bad++; $display("FAIL to_relock_cnt got=%0d exp=0", relock_cnt); end
  endtask

  // Lock glitch while qualifying; stdby_req is noise until RUN is reached.
  task automatic test_glitch();
    int f, l, d, run_exp;
    f = $urandom_range(RST_C + 2, LOCK_LAT);
    l = $urandom_range(1, 10);
    d = f - 2;
    run_exp = f + l + ST_C;
    extlock = 1'b1;
    apply_reset(2);
    for (int t = 1; t <= 40; t++) begin
      extlock   = 1'(!(t >= d && t < d + l));
      stdby_req = (t <= run_exp) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      total++; if (locked !== 1'(t >= run_exp)) begin bad++; $display("FAIL gl_locked t=%0d got=%b exp_run=%0d", t, locked, run_exp); end
      total++; if (pll_stdby !== 1'b0) begin bad++; $display("FAIL gl_pll_stdby t=%0d got=%b exp=0", t, pll_stdby); end
    end
    stdby_req = 1'b0;
    total++; if (relock_cnt !== 8'd0)  begin bad++; $display("FAIL gl_relock_cnt got=%0d exp=0", relock_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL gl_timeout_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_run_loss();
    int n, d, l, p, r, exp_cnt;
    extlock = 1'b1;
    apply_reset(2);
    wait_lock(30, n);
    total++; if (n != LOCK_LAT) begin bad++; $display("FAIL rl_first_lock got=%0d exp=%0d", n, LOCK_LAT); end
    d = $urandom_range(1, 10);
    l = $urandom_range(1, 20);
    p = d + 2;
    r = ((d + 7 > d + l + 2) ? d + 7 : d + l + 2) + ST_C;
    for (int t = 1; t <= r + 5; t++) begin
      extlock   = 1'(!(t >= d && t < d + l));
      stdby_req = (t > p && t <= r) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      exp_cnt = (t >= p) ? model_relock + 1 : model_relock;
      total++; if (pll_reset !== 1'(t >= p && t < p + RST_C)) begin bad++; $display("FAIL rl_pll_reset t=%0d got=%b p=%0d", t, pll_reset, p); end
      total++; if (locked !== 1'(t < p || t >= r)) begin bad++; $display("FAIL rl_locked t=%0d got=%b p=%0d r=%0d", t, locked, p, r); end
      total++; if (sys_rst !== 1'(t >= p && t < r)) begin bad++; $display("FAIL rl_sys_rst t=%0d got=%b", t, sys_rst); end
      total++; if (relock_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL rl_relock_cnt t=%0d got=%0d exp=%0d", t, relock_cnt, exp_cnt); end
    end
    model_relock++;
    stdby_req = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rl_timeout_err got=%b exp=0", timeout_err); end
  endtask

  // Standby request and lock loss become visible on the same edge.
  task automatic test_standby_race();
    int n, q, h;
    extlock = 1'b1;
    apply_reset(2);
    wait_lock(30, n);
    total++; if (n != LOCK_LAT) begin bad++; $display("FAIL sb_first_lock got=%0d exp=%0d", n, LOCK_LAT); end
    q = $urandom_range(3, 10);
    h = $urandom_range(1, 15);
    for (int t = 1; t <= q + h + LOCK_LAT + 5; t++) begin
      stdby_req = 1'(t >= q && t < q + h);
      if (t == q - 2)                    extlock = 1'b0;
      else if (t > q - 2 && t < q + h - 3) extlock = 1'($urandom_range(0, 1));
      else                               extlock = 1'b1;
      step();
      total++; if (pll_stdby !== 1'(t >= q && t < q + h)) begin bad++; $display("FAIL sb_pll_stdby t=%0d got=%b q=%0d h=%0d", t, pll_stdby, q, h); end
      total++; if (pll_reset !== 1'(t >= q + h && t < q + h + RST_C)) begin bad++; $display("FAIL sb_pll_reset t=%0d got=%b", t, pll_reset); end
      total++; if (locked !== 1'(t < q || t >= q + h + LOCK_LAT)) begin bad++; $display("FAIL sb_locked t=%0d got=%b", t, locked); end
      total++; if (sys_rst !== 1'(t >= q && t < q + h + LOCK_LAT)) begin bad++; $display("FAIL sb_sys_rst t=%0d got=%b", t, sys_rst); end
      total++; if (relock_cnt !== 8'(model_relock)) begin bad++; $display("FAIL sb_relock_cnt t=%0d got=%0d exp=%0d", t, relock_cnt, model_relock); end
    end
    stdby_req = 1'b0;
  endtask

  task automatic test_saturate_and_midreset();
    int n, m;
    bit dropped;
    extlock = 1'b1;
    apply_reset(2);
    wait_lock(30, n);
    for (int k = 1; k <= 258; k++) begin
      repeat ($urandom_range(0, 3)) step();
      extlock = 1'b0;
      step();
      extlock = 1'b1;
      n = -1;
      dropped = 1'b0;
      for (int i = 1; i <= 30 && n < 0; i++) begin
        step();
        if (!dropped && locked === 1'b0) dropped = 1'b1;
        else if (dropped && locked === 1'b1) n = i;
      end
      if (model_relock < 255) model_relock++;
      total++; if (n != LOCK_LAT + 2) begin bad++; $display("FAIL sat_relock_time k=%0d got=%0d exp=%0d", k, n, LOCK_LAT + 2); end
      total++; if (relock_cnt !== 8'(model_relock)) begin bad++; $display("FAIL sat_relock_cnt k=%0d got=%0d exp=%0d", k, relock_cnt, model_relock); end
    end
    // One more loss, then reset while the lock is qualifying in STABLE.
    m = $urandom_range(RST_C + 4, RST_C + ST_C + 2);
    extlock = 1'b0;
    step();
    extlock = 1'b1;
    repeat (m - 1) step();
    total++; if (relock_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", relock_cnt); end
    total++; if (sys_rst !== 1'b1)      begin bad++; $display("FAIL mid_pre_sys_rst got=%b exp=1", sys_rst); end
    reset = 1'b1;
    step();
    total++; if (pll_reset !== 1'b1)   begin bad++; $display("FAIL mid_pll_reset got=%b exp=1", pll_reset); end
    total++; if (pll_stdby !== 1'b0)   begin bad++; $display("FAIL mid_pll_stdby got=%b exp=0", pll_stdby); end
    total++; if (sys_rst !== 1'b1)     begin bad++; $display("FAIL mid_sys_rst got=%b exp=1", sys_rst); end
    total++; if (locked !== 1'b0)      begin bad++; $display("FAIL mid_locked got=%b exp=0", locked); end
    total++; if (relock_cnt !== 8'd0)  begin bad++; $display("FAIL mid_relock_cnt got=%0d exp=0", relock_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL mid_timeout_err got=%b exp=0", timeout_err); end
    reset = 1'b0;
    model_relock = 0;
    wait_lock(30, n);
    total++; if (n != LOCK_LAT) begin bad++; $display("FAIL mid_relock_time got=%0d exp=%0d", n, LOCK_LAT); end
  endtask

  initial begin
    reset     = 1'b1;
    extlock   = 1'b0;
    stdby_req = 1'b0;
    test_reset();
    test_lock_nominal();
    test_timeout();
    test_glitch();
    test_run_loss();
    test_standby_race();
    test_saturate_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
